// File: rtl/reg_write_arbiter.sv
// Purpose: arbitrates two register-file write requesters and runs a clear sweep of registers 1..31.
// Latency: 1 cycle from handshake to WE3/A3/WD3; a sweep is 31 back-to-back write cycles.
// Backpressure: at most one ready per cycle, both low during reset, clr_start and the sweep.
module reg_write_arbiter #(
  parameter int          PRIO_MODE = 0,
  parameter logic [31:0] CLR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic        last;     // requester granted by the most recent handshake
  logic        sel;      // requester that would win this cycle
  logic        arb_en;
  logic        hs0;
  logic        hs1;

  // Next state, winner selection and readys; readys are not gated by their own valid.
  always_comb begin
    state_nxt  = state;
    arb_en     = 1'b0;
    sel        = ~last;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    if (req0_valid && !req1_valid) begin
      sel = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      sel = 1'b1;
    end else if (req0_valid && req1_valid) begin
      sel = (PRIO_MODE == 1) ? 1'b0 : ~last;
    end

    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
        end else begin
          arb_en = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt == 5'd31) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      arb_en = 1'b0;
    end

    req0_ready = arb_en && !sel;
    req1_ready = arb_en && sel;
  end

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sweep counter tracks the address currently shown on A3 while in CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 5'd1;
    end else if (state == IDLE && clr_start) begin
      cnt <= 5'd1;
    end else if (state == CLEAR && cnt != 5'd31) begin
      cnt <= cnt + 5'd1;
    end
  end

  // Round-robin pointer moves only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (hs0) begin
      last <= 1'b0;
    end else if (hs1) begin
      last <= 1'b1;
    end
  end

  // Registered write port: the sweep's first write is loaded on the clr_start edge so
  // A3 equals the counter in every CLEAR cycle and the sweep never overlaps a granted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE3      <= 1'b0;
      A3       <= 5'd0;
      WD3      <= 32'd0;
      grant_id <= 1'b0;
      clr_busy <= 1'b0;
    end else if (state == IDLE && clr_start) begin
      WE3      <= 1'b1;
      A3       <= 5'd1;
      WD3      <= CLR_VALUE;
      grant_id <= 1'b0;
      clr_busy <= 1'b1;
    end else if (state == CLEAR) begin
      if (cnt == 5'd31) begin
        WE3      <= 1'b0;
        clr_busy <= 1'b0;
      end else begin
        WE3      <= 1'b1;
        A3       <= cnt + 5'd1;
        WD3      <= CLR_VALUE;
        grant_id <= 1'b0;
      end
    end else begin
      WE3 <= (hs0 && req0_addr != 5'd0) || (hs1 && req1_addr != 5'd0);
      if (hs0) begin
        A3       <= req0_addr;
        WD3      <= req0_data;
        grant_id <= 1'b0;
      end else if (hs1) begin
        A3       <= req1_addr;
        WD3      <= req1_data;
        grant_id <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        clr_start;

  logic        req0_ready, req1_ready, clr_busy, we3, grant_id;
  logic [4:0]  a3;
  logic [31:0] wd3;

  logic        req0_ready_p, req1_ready_p, clr_busy_p, we3_p, grant_id_p;
  logic [4:0]  a3_p;
  logic [31:0] wd3_p;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.PRIO_MODE(0), .CLR_VALUE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .WE3(we3), .A3(a3), .WD3(wd3), .grant_id(grant_id)
  );

  reg_write_arbiter #(.PRIO_MODE(1), .CLR_VALUE(32'h0000_0000)) dut_p (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready_p),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready_p),
    .clr_start(clr_start), .clr_busy(clr_busy_p),
    .WE3(we3_p), .A3(a3_p), .WD3(wd3_p), .grant_id(grant_id_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    clr_start  = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1111_2222;
    tick();
    tick();
    checks++;
    if ({req0_ready, req1_ready, req0_ready_p, req1_ready_p} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b%b%b%b want 0000", req0_ready, req1_ready, req0_ready_p, req1_ready_p);
    end
    checks++;
    if ({we3, a3, wd3, grant_id, clr_busy} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b a=%0d wd=%h g=%b busy=%b want all zero", we3, a3, wd3, grant_id, clr_busy);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if (we3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_write got we=%b want 0", we3);
    end
  endtask

  task automatic test_round_robin;
    logic g;
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      req0_valid = 1'b1; req0_addr = 5'(8 + i);  req0_data = 32'hA000_0000 + 32'(i);
      req1_valid = 1'b1; req1_addr = 5'(16 + i); req1_data = 32'hB000_0000 + 32'(i);
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {~g, g}) begin
        errors++;
        $display("FAIL rr_ready[%0d] got r0=%b r1=%b want r0=%b r1=%b", i, req0_ready, req1_ready, ~g, g);
      end
      tick();
      checks++;
      if (we3 !== 1'b1 || grant_id !== g ||
          a3 !== (g ? 5'(16 + i) : 5'(8 + i)) ||
          wd3 !== (g ? 32'hB000_0000 + 32'(i) : 32'hA000_0000 + 32'(i))) begin
        errors++;
        $display("FAIL rr_write[%0d] got we=%b g=%b a=%0d wd=%h want we=1 g=%b", i, we3, grant_id, a3, wd3, g);
      end
    end
    idle_inputs();
  endtask

  task automatic test_prio;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_addr = 5'(20 + i); req0_data = 32'hC000_0000 + 32'(i);
      req1_valid = 1'b1; req1_addr = 5'(24 + i); req1_data = 32'hD000_0000 + 32'(i);
      #1;
      checks++;
      if (req0_ready_p !== 1'b1 || req1_ready_p !== 1'b0) begin
        errors++;
        $display("FAIL prio_ready[%0d] got r0=%b r1=%b want r0=1 r1=0", i, req0_ready_p, req1_ready_p);
      end
      tick();
      checks++;
      if (we3_p !== 1'b1 || grant_id_p !== 1'b0 || a3_p !== 5'(20 + i) || wd3_p !== 32'hC000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL prio_write[%0d] got we=%b g=%b a=%0d wd=%h want we=1 g=0 a=%0d", i, we3_p, grant_id_p, a3_p, wd3_p, 20 + i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_single;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEAD_BEEF || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL single_write got we=%b a=%0d wd=%h g=%b want we=1 a=5 wd=deadbeef g=0", we3, a3, wd3, grant_id);
    end
    tick();
    checks++;
    if (we3 !== 1'b0 || a3 !== 5'd5 || wd3 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_hold got we=%b a=%0d wd=%h want we=0 a=5 wd=deadbeef", we3, a3, wd3);
    end
  endtask

  task automatic test_addr0;
    // Last grant was requester 0, so the idle pointer prefers requester 1.
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ptr_pre got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready);
    end
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL addr0_ready got r1=%b want 1", req1_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (we3 !== 1'b0) begin
      errors++;
      $display("FAIL addr0_we got we=%b want 0", we3);
    end
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ptr_post got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
  endtask

  task automatic test_clear;
    int bad;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h0000_0033;
    tick();
    idle_inputs();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0055;
    clr_start  = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_ready got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
    end
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd3 || wd3 !== 32'h0000_0033 || grant_id !== 1'b1 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL pre_clr_write got we=%b a=%0d wd=%h g=%b busy=%b want we=1 a=3 wd=33 g=1 busy=0", we3, a3, wd3, grant_id, clr_busy);
    end
    tick();
    clr_start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 31; k++) begin
      if (k == 15) clr_start = 1'b1;
      if (k == 16) clr_start = 1'b0;
      #1;
      if (clr_busy !== 1'b1 || we3 !== 1'b1 || a3 !== 5'(k) || wd3 !== 32'd0 || grant_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        if (bad == 1)
          $display("FAIL sweep[%0d] got busy=%b we=%b a=%0d wd=%h r0=%b want busy=1 we=1 a=%0d wd=0 r0=0", k, clr_busy, we3, a3, wd3, req0_ready, k);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || we3 !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL sweep_end got busy=%b we=%b r0=%b want busy=0 we=0 r0=1", clr_busy, we3, req0_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h0000_0055 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL post_clr_write got we=%b a=%0d wd=%h g=%b want we=1 a=7 wd=55 g=0", we3, a3, wd3, grant_id);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int bad;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    checks++;
    if (a3 !== 5'd10 || we3 !== 1'b1 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_pos got a=%0d we=%b busy=%b want a=10 we=1 busy=1", a3, we3, clr_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (we3 !== 1'b0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got we=%b busy=%b want we=0 busy=0", we3, clr_busy);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (we3 !== 1'b0 || clr_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_resume got %0d cycles with write or busy want 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_prio();
    test_single();
    test_addr0();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin arbitration and 1 = fixed priority to requester 0.
REQ-002 The block SHALL have parameter CLR_VALUE, default 32'h0000_0000, meaning the data written to every register during a clear sweep.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports req0_valid (input, 1), req0_addr (input, 5) and req0_data (input, 32): the requester 0 (core writeback) write request.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: the requester 0 write is accepted in the current cycle.
REQ-007 The block SHALL have ports req1_valid (input, 1), req1_addr (input, 5), req1_data (input, 32) and req1_ready (output, 1): the requester 1 (debug/loader) write request, with the same meaning as requester 0.
REQ-008 The block SHALL have port clr_start, input, 1 bit: a one-cycle pulse that starts a clear sweep of registers 1..31.
REQ-009 The block SHALL have port clr_busy, output, 1 bit: high while the clear sweep is in progress.
REQ-010 The block SHALL have ports WE3 (output, 1), A3 (output, 5) and WD3 (output, 32): the registered write port that drives the register file.
REQ-011 The block SHALL have port grant_id, output, 1 bit: the requester whose write is on WE3/A3/WD3 in the current cycle (0 during a clear).

Function
REQ-012 The block SHALL use a two-state FSM: IDLE and CLEAR.
REQ-013 In IDLE with clr_start high, the block SHALL move to CLEAR at the next edge, and both readys SHALL be low in that cycle.
REQ-014 In IDLE with clr_start low, a handshake occurs when reqN_valid and reqN_ready are both high; at most one ready SHALL be high per cycle.
REQ-015 A ready SHALL be a combinational function of the valids, the FSM state, clr_start and the round-robin pointer, and SHALL NOT depend on its own valid being high.
REQ-016 Ready SHALL be low on both requesters in CLEAR.
REQ-017 In arbitration, if only one valid is high, that requester SHALL be granted.
REQ-018 In arbitration with both valids high: with PRIO_MODE=0 the requester not granted last SHALL be granted; with PRIO_MODE=1 requester 0 SHALL be granted.
REQ-019 The round-robin pointer SHALL update only on a handshake and SHALL reset to "last = 1", so that requester 0 wins first.
REQ-020 With no valid high, ready SHALL point to the pointer's preferred requester.
REQ-021 A handshake in cycle N SHALL produce WE3=1 with A3 and WD3 equal to the granted address and data, plus grant_id, in cycle N+1 only (latency 1, registered).
REQ-022 A handshake with address 0 SHALL be accepted (ready high, pointer updated) but SHALL produce WE3=0 in N+1.
REQ-023 With no handshake in cycle N and the FSM not in CLEAR, WE3 SHALL be 0 in N+1; A3 and WD3 SHALL hold their last values.
REQ-024 CLEAR SHALL use a 5-bit counter loaded with 1 on entry.
REQ-025 Each CLEAR cycle SHALL drive WE3=1, A3=counter and WD3=CLR_VALUE (registered outputs), then increment the counter.
REQ-026 After the cycle with A3=31, the FSM SHALL return to IDLE, so a sweep is exactly 31 consecutive write cycles.
REQ-027 clr_busy SHALL be high from the edge after clr_start through the last sweep write cycle, i.e. exactly 31 cycles.
REQ-028 clr_start SHALL be ignored while in CLEAR.
REQ-029 A write accepted in the cycle before clr_start SHALL still appear on the port in the clr_start cycle; the sweep SHALL begin the cycle after, so the two never collide.

Reset
REQ-030 While rst is sampled high, the block SHALL set: state IDLE, counter 1, pointer "last = 1", and WE3, A3, WD3, grant_id and clr_busy all 0.
REQ-031 While rst is high, both readys SHALL be low.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no further writes; the sweep SHALL NOT resume after reset.

Verification
REQ-033 Bench scenario, single write: req0 valid with addr=5, data=0xDEADBEEF -> req0_ready=1 that cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF, grant_id=0.
REQ-034 Bench scenario, contention with PRIO_MODE=0: both valid for 4 cycles -> grants alternate 0,1,0,1; each WE3 cycle carries the matching addr/data.
REQ-035 Bench scenario, contention with PRIO_MODE=1: both valid for 3 cycles -> requester 0 is granted every cycle and req1_ready stays 0.
REQ-036 Bench scenario, address 0: req1 with addr=0, data=0x1234 -> req1_ready=1; next cycle WE3=0.
REQ-037 Bench scenario, clear: clr_start pulse while req0 is valid -> readys 0; 31 cycles of WE3=1 with A3=1..31 and WD3=0; clr_busy high for 31 cycles; req0 is then granted on the first IDLE cycle.
REQ-038 Bench scenario, reset mid-sweep: rst at A3=10 -> the next cycle has WE3=0 and clr_busy=0; no writes follow until a new request arrives.
